// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, frame state encoding and character-length clamp
package uart_pkg;
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  localparam logic [1:0] PAR_MARK = 2'd3;
  localparam int MIN_DATA_BITS = 5;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
  function automatic logic [3:0] eff_len(input logic [3:0] db, input int max_w);
    return (int'(db) < MIN_DATA_BITS) ? 4'(MIN_DATA_BITS) : (int'(db) > max_w) ? 4'(max_w) : db;
  endfunction
endpackage

// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: host-side character FIFO write port and status
interface uart_tx_cfg_if #(parameter int DATA_W = 9);
  logic [DATA_W-1:0] fifo_in;
  logic              fifo_write;
  logic [15:0]       fifo_level;
  logic              fifo_full;
  modport master (output fifo_in, fifo_write, input fifo_level, fifo_full);
  modport slave  (input fifo_in, fifo_write, output fifo_level, fifo_full);
endinterface

// File: rtl/axi_fifo.sv
// axi_fifo: 2^SIZE-entry valid/ready FIFO reporting free entries
module axi_fifo #(
  parameter int SIZE = 4,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_tdata,
  input  logic          i_tvalid,
  output logic          i_tready,
  output logic [DW-1:0] o_tdata,
  output logic          o_tvalid,
  input  logic          o_tready,
  output logic [15:0]   o_free
);
  localparam int DEPTH = 1 << SIZE;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [SIZE-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [SIZE:0]   cnt_q, cnt_d;
  logic            push, pop;
  assign i_tready = ~cnt_q[SIZE];
  assign o_tvalid = cnt_q != '0;
  assign o_tdata  = mem_q[rd_q];
  assign o_free   = 16'(DEPTH) - 16'(cnt_q);
  assign push     = i_tvalid & i_tready;
  assign pop      = o_tready & o_tvalid;
  always_comb begin
    wr_d  = wr_q + {{(SIZE-1){1'b0}}, push};
    rd_d  = rd_q + {{(SIZE-1){1'b0}}, pop};
    cnt_d = cnt_q + {{SIZE{1'b0}}, push} - {{SIZE{1'b0}}, pop};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= i_tdata;
endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running bit-time counter producing a tick every clkdiv+1 clocks
module uart_baud_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] clkdiv,
  output logic        tick,
  output logic        baudclk
);
  logic [15:0] baud_ctr_q, baud_ctr_d;
  // >= so that lowering clkdiv below the count wraps without a tick
  always_comb baud_ctr_d = (baud_ctr_q >= clkdiv) ? '0 : baud_ctr_q + 16'd1;
  assign tick    = baud_ctr_q == clkdiv;
  assign baudclk = baud_ctr_q == 16'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) baud_ctr_q <= '0;
    else baud_ctr_q <= baud_ctr_d;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: FIFO-buffered UART transmitter with runtime length, parity, stop bits and break
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int DATA_W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_cfg_if.slave host,
  input  logic [15:0]  clkdiv,
  input  logic [3:0]   data_bits,
  input  logic [1:0]   parity_mode,
  input  logic         stop2,
  input  logic         tx_en,
  input  logic         brk,
  output logic         busy,
  output logic         tx_done,
  output logic         baudclk,
  output logic         tx
);
  logic              tick, f_valid, f_pop, in_rdy, sched, stop_last, par_x, new_par;
  logic [DATA_W-1:0] f_data, shift_q, shift_d;
  logic [3:0]        new_len, len_q, len_d, cnt_q, cnt_d;
  logic              par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
  logic              stop_hi_q, stop_hi_d, brk_stop_q, brk_stop_d, tx_q, tx_d;
  state_t            state_q, state_d;
  axi_fifo #(.SIZE(SIZE), .DW(DATA_W)) u_fifo (
    .clk(clk), .rst_n(rst_n),
    .i_tdata(host.fifo_in), .i_tvalid(host.fifo_write), .i_tready(in_rdy),
    .o_tdata(f_data), .o_tvalid(f_valid), .o_tready(f_pop),
    .o_free(host.fifo_level)
  );
  assign host.fifo_full = ~in_rdy;
  uart_baud_gen u_baud (.clk(clk), .rst_n(rst_n), .clkdiv(clkdiv), .tick(tick), .baudclk(baudclk));
  assign new_len = eff_len(data_bits, DATA_W);
  always_comb begin
    par_x = 1'b0;
    for (int i = 0; i < DATA_W; i++) par_x ^= f_data[i] & (i < int'(new_len));
    new_par = (parity_mode == PAR_MARK) ? 1'b1 : (parity_mode == PAR_ODD) ? ~par_x : par_x;
  end
  assign busy      = state_q != S_IDLE;
  assign tx        = tx_q;
  assign stop_last = brk_stop_q | ~stop2_q | stop_hi_q;
  // IDLE and the final stop tick share the same frame-launch rules
  assign sched     = tick & ((state_q == S_IDLE) | ((state_q == S_STOP) & stop_last));
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_hi_d  = stop_hi_q;
    brk_stop_d = brk_stop_q;
    tx_d       = tx_q;
    f_pop      = 1'b0;
    tx_done    = 1'b0;
    if (sched) begin
      tx_done    = (state_q == S_STOP) & ~brk_stop_q;
      stop_hi_d  = 1'b0;
      brk_stop_d = 1'b0;
      if (brk) begin
        state_d = S_BREAK;
        tx_d    = 1'b0;
      end else if (tx_en & f_valid) begin
        f_pop     = 1'b1;
        shift_d   = f_data;
        len_d     = new_len;
        par_en_d  = parity_mode != PAR_NONE;
        par_bit_d = new_par;
        stop2_d   = stop2;
        state_d   = S_START;
        tx_d      = 1'b0;
      end else begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    end else if (tick) begin
      case (state_q)
        S_START: begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = 4'd1;
          state_d = S_DATA;
        end
        S_DATA:
          if (cnt_q == len_q) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 4'd1;
          end
        S_PARITY: begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
        S_STOP: stop_hi_d = 1'b1;
        S_BREAK:
          if (!brk) begin
            state_d    = S_STOP;
            tx_d       = 1'b1;
            brk_stop_d = 1'b1;
          end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_hi_q  <= 1'b0;
      brk_stop_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_hi_q  <= stop_hi_d;
      brk_stop_q <= brk_stop_d;
      tx_q       <= tx_d;
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: table, random and corner-sequence checks of uart_tx_cfg against a frame model
module tb_uart_tx_cfg;
  localparam int DW = 9;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] clkdiv = 16'd3;
  logic [3:0]  data_bits = 4'd8;
  logic [1:0]  parity_mode = 2'd0;
  logic        stop2 = 1'b0, tx_en = 1'b1, brk = 1'b0;
  logic        busy, tx_done, baudclk, tx;
  int          n_cmp = 0, n_err = 0;
  uart_tx_cfg_if #(.DATA_W(DW)) bus ();
  uart_tx_cfg #(.SIZE(4), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .host(bus), .clkdiv(clkdiv), .data_bits(data_bits),
    .parity_mode(parity_mode), .stop2(stop2), .tx_en(tx_en), .brk(brk),
    .busy(busy), .tx_done(tx_done), .baudclk(baudclk), .tx(tx)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Frame as it should appear on the line: start, clamped data LSB first, optional parity, stops
  function automatic int model_frame(input logic [8:0] c, input int db, input int pm, input int s2,
                                     output logic [15:0] bits);
    int eff, n, ones;
    eff = db < 5 ? 5 : (db > DW ? DW : db);
    bits = '1;
    bits[0] = 1'b0;
    n = 1;
    ones = 0;
    for (int i = 0; i < eff; i++) begin
      bits[n] = c[i];
      ones += int'(c[i]);
      n++;
    end
    if (pm != 0) begin
      bits[n] = (pm == 3) ? 1'b1 : (pm == 2) ? ~ones[0] : ones[0];
      n++;
    end
    return n + (s2 != 0 ? 2 : 1);
  endfunction

  task automatic set_cfg(input int div, input int db, input int pm, input int s2);
    @(negedge clk);
    clkdiv = 16'(div);
    data_bits = db[3:0];
    parity_mode = pm[1:0];
    stop2 = s2[0];
  endtask

  task automatic write_char(input logic [8:0] c);
    @(negedge clk);
    bus.fifo_in = c;
    bus.fifo_write = 1'b1;
    @(negedge clk);
    bus.fifo_write = 1'b0;
  endtask

  task automatic wait_start(output int w);
    w = 0;
    while (tx !== 1'b0 && w < 20000) begin
      w++;
      @(negedge clk);
    end
    chk("start_bit_seen", 32'(tx), 0);
  endtask

  task automatic sample_bits(input int n, input int div, output logic [15:0] bits,
                             output int dcnt, output int dpos, output int uns);
    bits = '1;
    dcnt = 0;
    dpos = -1;
    uns = 0;
    for (int b = 0; b < n; b++)
      for (int k = 0; k <= div; k++) begin
        if (k == 0) bits[b] = tx;
        else if (tx !== bits[b]) uns++;
        if (tx_done === 1'b1) begin
          dcnt++;
          dpos = b * (div + 1) + k;
        end
        @(negedge clk);
      end
  endtask

  task automatic check_frame(input string name, input logic [8:0] c, input int db, input int pm,
                             input int s2, input int div, output int w, output logic [15:0] got);
    logic [15:0] exp;
    int n, dcnt, dpos, uns;
    n = model_frame(c, db, pm, s2, exp);
    wait_start(w);
    sample_bits(n, div, got, dcnt, dpos, uns);
    chk({name, " bits"}, 32'(got), 32'(exp));
    chk({name, " bit_width"}, uns, 0);
    chk({name, " done_cnt"}, dcnt, 1);
    chk({name, " done_pos"}, dpos, n * (div + 1) - 1);
  endtask

  typedef struct {
    logic [8:0] c;
    int db, pm, s2, div, len;
    logic par;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int w, w2, k, lowc, hic, dn, busyc, bc;
    logic [15:0] got, exp;
    logic [8:0] ch[17];
    bus.fifo_in = '0;
    bus.fifo_write = 1'b0;
    tbl[0] = '{9'h0A5, 8, 0, 0, 3, 10, 1'b0};
    tbl[1] = '{9'h041, 7, 1, 0, 3, 10, 1'b0};
    tbl[2] = '{9'h041, 7, 2, 0, 3, 10, 1'b1};
    tbl[3] = '{9'h1C1, 7, 1, 0, 3, 10, 1'b0};
    tbl[4] = '{9'h1C1, 9, 1, 0, 2, 12, 1'b0};
    tbl[5] = '{9'h01F, 2, 3, 1, 0, 9, 1'b1};
    tbl[6] = '{9'h155, 15, 2, 0, 1, 12, 1'b0};
    tbl[7] = '{9'h003, 5, 1, 1, 2, 9, 1'b0};

    // reset state and baud strobe rate
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst tx", 32'(tx), 1);
    chk("rst busy", 32'(busy), 0);
    chk("rst tx_done", 32'(tx_done), 0);
    chk("rst level", 32'(bus.fifo_level), 16);
    chk("rst full", 32'(bus.fifo_full), 0);
    chk("rst baudclk", 32'(baudclk), 0);
    bc = 0;
    repeat (12) begin
      bc += int'(baudclk);
      @(negedge clk);
    end
    chk("baudclk rate", bc, 3);

    // table-driven frames
    for (int i = 0; i < 8; i++) begin
      set_cfg(tbl[i].div, tbl[i].db, tbl[i].pm, tbl[i].s2);
      write_char(tbl[i].c);
      check_frame($sformatf("tbl%0d", i), tbl[i].c, tbl[i].db, tbl[i].pm, tbl[i].s2, tbl[i].div, w, got);
      if (tbl[i].pm != 0)
        chk($sformatf("tbl%0d parity", i), 32'(got[tbl[i].len - 1 - (tbl[i].s2 != 0 ? 2 : 1)]), 32'(tbl[i].par));
      if (tbl[i].div == 0) chk($sformatf("tbl%0d latency", i), w, 1);
      chk($sformatf("tbl%0d idle busy", i), 32'(busy), 0);
      chk($sformatf("tbl%0d idle tx", i), 32'(tx), 1);
    end

    // randomized frames
    for (int i = 0; i < 30; i++) begin
      int rdiv, rdb, rpm, rs2;
      logic [8:0] rc;
      rdiv = int'($urandom_range(0, 4));
      rdb = int'($urandom_range(0, 15));
      rpm = int'($urandom_range(0, 3));
      rs2 = int'($urandom_range(0, 1));
      rc = 9'($urandom);
      set_cfg(rdiv, rdb, rpm, rs2);
      write_char(rc);
      check_frame($sformatf("rnd%0d", i), rc, rdb, rpm, rs2, rdiv, w, got);
    end

    // push and pop in the same clock
    set_cfg(0, 8, 0, 0);
    @(negedge clk);
    bus.fifo_in = 9'h012;
    bus.fifo_write = 1'b1;
    @(negedge clk);
    bus.fifo_in = 9'h034;
    @(negedge clk);
    bus.fifo_write = 1'b0;
    chk("pushpop level", 32'(bus.fifo_level), 15);
    check_frame("pushpop a", 9'h012, 8, 0, 0, 0, w, got);
    check_frame("pushpop b", 9'h034, 8, 0, 0, 0, w, got);

    // back-to-back frames with two stop bits
    set_cfg(3, 8, 0, 1);
    write_char(9'h000);
    write_char(9'h0FF);
    check_frame("b2b first", 9'h000, 8, 0, 1, 3, w, got);
    check_frame("b2b second", 9'h0FF, 8, 0, 1, 3, w2, got);
    chk("b2b gap", w2, 0);
    chk("b2b level", 32'(bus.fifo_level), 16);
    chk("b2b busy", 32'(busy), 0);

    // FIFO overflow
    set_cfg(0, 9, 0, 0);
    tx_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      ch[i] = 9'((i * 37 + 5) & 9'h1FF);
      write_char(ch[i]);
      if (i == 4) chk("ovf level5", 32'(bus.fifo_level), 11);
      if (i == 15) begin
        chk("ovf full16", 32'(bus.fifo_full), 1);
        chk("ovf level16", 32'(bus.fifo_level), 0);
      end
    end
    chk("ovf full17", 32'(bus.fifo_full), 1);
    chk("ovf level17", 32'(bus.fifo_level), 0);
    chk("ovf idle", 32'(busy), 0);
    tx_en = 1'b1;
    for (int i = 0; i < 16; i++) check_frame($sformatf("ovf%0d", i), ch[i], 9, 0, 0, 0, w, got);
    lowc = 0;
    repeat (40) begin
      lowc += int'(tx === 1'b0);
      @(negedge clk);
    end
    chk("ovf no 17th frame", lowc, 0);
    chk("ovf level end", 32'(bus.fifo_level), 16);

    // break deferred until the frame ends, then held and released
    set_cfg(3, 8, 0, 0);
    write_char(9'h055);
    fork
      check_frame("brk frame", 9'h055, 8, 0, 0, 3, w, got);
      begin
        int kk;
        kk = 0;
        while (tx !== 1'b0 && kk < 2000) begin
          kk++;
          @(negedge clk);
        end
        repeat (8) @(negedge clk);
        brk = 1'b1;
      end
    join
    lowc = 0;
    busyc = 0;
    dn = 0;
    repeat (30) begin
      lowc += int'(tx === 1'b0);
      busyc += int'(busy === 1'b1);
      dn += int'(tx_done === 1'b1);
      @(negedge clk);
    end
    chk("brk low", lowc, 30);
    chk("brk busy", busyc, 30);
    brk = 1'b0;
    k = 0;
    while (tx !== 1'b1 && k < 20) begin
      k++;
      dn += int'(tx_done === 1'b1);
      @(negedge clk);
    end
    hic = 0;
    while (busy === 1'b1 && hic < 50) begin
      hic += int'(tx === 1'b1);
      dn += int'(tx_done === 1'b1);
      @(negedge clk);
    end
    chk("brk stop width", hic, 4);
    chk("brk no done", dn, 0);
    chk("brk end tx", 32'(tx), 1);

    // asynchronous reset in the middle of a data bit
    set_cfg(3, 8, 0, 0);
    tx_en = 1'b0;
    repeat (4) write_char(9'h000);
    tx_en = 1'b1;
    wait_start(w);
    repeat (10) @(negedge clk);
    chk("rst mid low", 32'(tx), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async tx", 32'(tx), 1);
    chk("rst async busy", 32'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst level", 32'(bus.fifo_level), 16);
    lowc = 0;
    repeat (60) begin
      lowc += int'(tx === 1'b0);
      @(negedge clk);
    end
    chk("rst no frame", lowc, 0);

    // clkdiv lowered below the running count
    set_cfg(100, 8, 0, 0);
    write_char(9'h00F);
    wait_start(w);
    lowc = 0;
    for (int j = 0; j < 50; j++) begin
      if (j == 1) chk("div baudclk", 32'(baudclk), 1);
      lowc += int'(tx === 1'b0);
      @(negedge clk);
    end
    clkdiv = 16'd2;
    k = 0;
    while (tx === 1'b0 && k < 300) begin
      lowc++;
      k++;
      @(negedge clk);
    end
    chk("div start width", lowc, 54);
    begin
      int n, dcnt, dpos, uns;
      n = model_frame(9'h00F, 8, 0, 0, exp);
      sample_bits(n - 1, 2, got, dcnt, dpos, uns);
      chk("div bits", 32'(got), 32'({1'b1, exp[15:1]}));
      chk("div bit_width", uns, 0);
      chk("div done_pos", dpos, (n - 1) * 3 - 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
